// File: rtl/ime_bist_pattern_gen.sv
// ime_bist_pattern_gen: streaming IME BIST smoke-pattern source
// (uniform, dirac, symmetric perturbation, LFSR pseudo-random) feeding the
// IME datapath input mux over a valid/ready handshake.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i, abort_i  run control from the BIST controller
//   mode_i            0 uniform, 1 dirac, 2 sym_perturb, 3 lfsr, 4-7 illegal
//   repeat_i          extra passes (total passes = repeat_i + 1)
//   seed_i            LFSR seed (0 is replaced by 1)
//   out_ready_i       consumer ready
//   out_valid_o, out_sample_o, out_idx_o, out_last_o   output beat
//   busy_o, done_o, err_o                               status
module ime_bist_pattern_gen #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_CH   = 1,
  parameter int unsigned REP_W    = 4,
  parameter int unsigned LFSR_LEN = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_i,
  input  logic                                 abort_i,
  input  logic [2:0]                           mode_i,
  input  logic [REP_W-1:0]                     repeat_i,
  input  logic [31:0]                          seed_i,
  input  logic                                 out_ready_i,
  output logic                                 out_valid_o,
  output logic [NUM_CH*(3*DATA_W+15)-1:0]      out_sample_o,
  output logic [7:0]                           out_idx_o,
  output logic                                 out_last_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int unsigned SAMPLE_W = 3*DATA_W + 15;
  localparam int unsigned BUS_W    = NUM_CH*SAMPLE_W;

  localparam logic [DATA_W-1:0] ONE    = DATA_W'(1) << (DATA_W-8);
  localparam logic [DATA_W-1:0] DP     = DATA_W'(1) << (DATA_W-2);
  localparam logic [DATA_W-1:0] SP     = DATA_W'(3) << (DATA_W-9);
  localparam logic [DATA_W-1:0] LW     = DATA_W'(1) << (DATA_W-12);
  localparam logic [DATA_W-1:0] DP_M1  = DP - DATA_W'(1);
  localparam logic [DATA_W-1:0] SP_NEG = DATA_W'(0) - SP;
  localparam logic [DATA_W-1:0] P_MASK = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [31:0]       TAPS   = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [REP_W-1:0]   pass_q, pass_d;
  logic [7:0]         k_q, k_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic               valid_d, last_d, busy_d, done_d, err_d;
  logic [7:0]         idx_d;
  logic [BUS_W-1:0]   sample_d;

  // Galois right-shift LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
  endfunction

  // Index of the final sample in a pass for a given mode
  function automatic logic [7:0] last_k(input logic [1:0] mode);
    case (mode)
      2'd0:    return 8'd2;
      2'd1:    return 8'd1;
      2'd2:    return 8'd2;
      default: return 8'(LFSR_LEN-1);
    endcase
  endfunction

  // Build all channels of the beat for sample index k
  function automatic logic [BUS_W-1:0] build_sample(input logic [1:0]  mode,
                                                   input logic [7:0]  k,
                                                   input logic [31:0] lfsr);
    logic [BUS_W-1:0]  s;
    logic [DATA_W-1:0] p, q, lw;
    logic [1:0]        tree, pwl;
    logic [3:0]        eps, dl;
    logic [31:0]       rot;
    s = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      // channel c sees the LFSR state rotated right by 8*c bits
      rot  = 32'({lfsr, lfsr} >> (8*c));
      tree = 2'(k + 8'(c));
      case (mode)
        2'd0: begin
          p = ONE >> k; q = ONE >> k; lw = '0;
          pwl = (k == 8'd0) ? 2'd0 : 2'd1;
          eps = 4'(k + 8'd1); dl = 4'(k + 8'd1);
        end
        2'd1: begin
          p = DP; q = '0; lw = DP_M1;
          pwl = 2'd0; eps = 4'd0; dl = 4'(k);
        end
        2'd2: begin
          p = SP; q = k[0] ? SP : SP_NEG; lw = LW;
          pwl = (k == 8'd2) ? 2'd3 : 2'd2;
          eps = 4'(k + 8'd4); dl = 4'(k + 8'd4);
        end
        default: begin
          // p takes the low DATA_W-1 bits, q the top DATA_W-1 bits, both zero-extended
          p = DATA_W'(rot) & P_MASK;
          q = DATA_W'(rot >> (33-DATA_W));
          lw = '0;
          pwl = rot[1:0]; eps = rot[5:2]; dl = rot[9:6];
        end
      endcase
      s[c*SAMPLE_W +: SAMPLE_W] = {p, q, lw, {1'b0, mode}, tree, pwl, eps, dl};
    end
    return s;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rep_d   = rep_q;
    pass_d  = pass_q;
    k_d     = k_q;
    lfsr_d  = lfsr_q;
    valid_d = out_valid_o;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (mode_i <= 3'd3) begin
            state_d = RUN;
            mode_d  = mode_i[1:0];
            rep_d   = repeat_i;
            pass_d  = '0;
            k_d     = '0;
            lfsr_d  = (seed_i == 32'h0) ? 32'h1 : seed_i;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (out_valid_o && out_ready_i) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (k_q == last_k(mode_q)) begin
            k_d = '0;
            if (pass_q == rep_q) begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              pass_d = REP_W'(pass_q + 1'b1);
            end
          end else begin
            k_d = 8'(k_q + 8'd1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d   = (state_d == RUN);
    idx_d    = valid_d ? k_d : 8'd0;
    last_d   = valid_d && (pass_d == rep_d) && (k_d == last_k(mode_d));
    sample_d = valid_d ? build_sample(mode_d, k_d, lfsr_d) : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      rep_q        <= '0;
      pass_q       <= '0;
      k_q          <= '0;
      lfsr_q       <= 32'h1;
      out_valid_o  <= 1'b0;
      out_sample_o <= '0;
      out_idx_o    <= '0;
      out_last_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rep_q        <= rep_d;
      pass_q       <= pass_d;
      k_q          <= k_d;
      lfsr_q       <= lfsr_d;
      out_valid_o  <= valid_d;
      out_sample_o <= sample_d;
      out_idx_o    <= idx_d;
      out_last_o   <= last_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      err_o        <= err_d;
    end
  end

endmodule
